// File: rtl/store_monitor.sv
// rtl/store_monitor.sv - store mailbox monitor with watchdog, statistics and optional trace ring (STORE_MON_TRACE_EN)
module store_monitor #(
    parameter logic [31:0] PASS_ADDR      = 32'd32,
    parameter logic [31:0] FAIL_ADDR      = 32'd16,
    parameter logic [31:0] MAGIC          = 32'd15,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          TRACE_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic        rd_en,
    input  logic [3:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        pass,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_PASS    = 2'b01,
        ST_FAIL    = 2'b10,
        ST_TIMEOUT = 2'b11
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [31:0] store_cnt_q, store_cnt_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] pop_data;
    logic        pass_hit, fail_hit;

    assign pass_hit = memwrite && (writedata == MAGIC) && (dataadr == PASS_ADDR);
    assign fail_hit = memwrite && (writedata == MAGIC) && (dataadr == FAIL_ADDR);

    // Next state and statistics; everything freezes once a terminal state is reached
    always_comb begin
        state_d     = state_q;
        store_cnt_d = store_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        if (state_q == ST_RUN) begin
            // The cycle counter stops at the timeout value so it reads back as TIMEOUT_CYCLES-1
            if (cycle_cnt_q != TIMEOUT_LAST)
                cycle_cnt_d = cycle_cnt_q + 32'd1;
            if (memwrite && (store_cnt_q != 32'hFFFF_FFFF))
                store_cnt_d = store_cnt_q + 32'd1;
            // A hit on the final watchdog cycle still beats the timeout; FAIL beats PASS
            if (fail_hit)
                state_d = ST_FAIL;
            else if (pass_hit)
                state_d = ST_PASS;
            else if (cycle_cnt_q == TIMEOUT_LAST)
                state_d = ST_TIMEOUT;
        end
        done_d = (state_d != ST_RUN);
        pass_d = (state_d == ST_PASS);
    end

    // Register read mux; reads see the values before this cycle's update
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            case (rd_addr)
                4'h0:    rd_data_d = {29'b0, done_q, state_q};
                4'h4:    rd_data_d = store_cnt_q;
                4'h8:    rd_data_d = cycle_cnt_q;
                4'hC:    rd_data_d = pop_data;
                default: rd_data_d = 32'd0;
            endcase
        end
    end

    // Control and statistics registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            store_cnt_q <= 32'd0;
            cycle_cnt_q <= 32'd0;
            rd_data_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            store_cnt_q <= store_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign state   = state_q;

`ifdef STORE_MON_TRACE_EN
    localparam int PW = $clog2(TRACE_DEPTH);

    logic [30:0] trace_q [TRACE_DEPTH];
    logic [30:0] trace_d [TRACE_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push, pop_ok, full;

    assign push   = (state_q == ST_RUN) && memwrite;
    assign pop_ok = rd_en && (rd_addr == 4'hC) && (count_q != '0);
    assign full   = (count_q == (PW+1)'(TRACE_DEPTH));

    // Trace ring: pop reads the oldest entry before any same-cycle push lands
    always_comb begin
        trace_d  = trace_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        pop_data = 32'd0;
        if (pop_ok) begin
            pop_data = {ovf_q, trace_q[rd_ptr_q]};
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            trace_d[wr_ptr_q] = dataadr[30:0];
            wr_ptr_d          = wr_ptr_q + 1'b1;
            if (!pop_ok) begin
                if (full) begin
                    // Overwrite the oldest entry: the read pointer skips past it
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    ovf_d    = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end else if (pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Trace ring storage and pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TRACE_DEPTH; i++)
                trace_q[i] <= 31'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            trace_q  <= trace_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end
`else
    assign pop_data = 32'd0;
`endif

endmodule

// File: doc/store_monitor.md
Name: store_monitor

Overview:
- Memory-mapped responder on the processor data-memory write port; the hardware counterpart of a bench-side store checker.
- Watches every store (memwrite/dataadr/writedata) leaving the core and decodes pass/fail mailbox writes.
- Runs a cycle watchdog and keeps store/cycle statistics, readable through a small register read port.
- Sits beside data memory under top; drives done/pass flags for silicon/FPGA runs without a simulator.

Parameters:
- PASS_ADDR, 32, store address that signals pass
- FAIL_ADDR, 16, store address that signals fail
- MAGIC, 15, writedata value required for a mailbox hit
- TIMEOUT_CYCLES, 1000, cycles in RUN before TIMEOUT (must be >= 2)
- TRACE_DEPTH, 8, entries in store-address trace ring (power of 2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- memwrite  in  1  store strobe from core, one store per cycle when high
- dataadr  in  32  store/read byte address from core
- writedata  in  32  store data from core
- rd_en  in  1  register read request
- rd_addr  in  4  register byte offset (0x0,0x4,0x8,0xC)
- rd_data  out  32  read result, valid the cycle after rd_en
- done  out  1  high in PASS, FAIL or TIMEOUT
- pass  out  1  high only in PASS
- state  out  2  00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT

Behaviour:
- Reset (reset==0, async): state=RUN, done=0, pass=0, rd_data=0, store_cnt=0, cycle_cnt=0, trace ring empty.
- RUN: cycle_cnt += 1 each cycle. On memwrite, store_cnt += 1 (saturating at 0xFFFFFFFF).
- Hit: memwrite & writedata==MAGIC & dataadr==PASS_ADDR -> PASS next cycle. Same with FAIL_ADDR -> FAIL.
- Priority: if PASS_ADDR==FAIL_ADDR, FAIL wins.
- Timeout: cycle_cnt reaches TIMEOUT_CYCLES-1 with no hit -> TIMEOUT next cycle. If a hit occurs on that same cycle, the hit wins.
- PASS/FAIL/TIMEOUT are terminal until reset. Counters freeze, stores still ignored, read port still live.
- done/pass/state are registered outputs: one cycle latency from the hit or timeout cycle.
- Register map (rd_data registered, 1-cycle latency, unaffected by memwrite on the same cycle):
  - 0x0: {29'b0, done, state}
  - 0x4: store_cnt
  - 0x8: cycle_cnt
  - 0xC: trace pop (see Optional Feature)
- Any other rd_addr returns 0. With rd_en low, rd_data holds its last value.
- Read and store in the same cycle: the read returns the pre-update value.

Optional Feature:
- Macro: STORE_MON_TRACE_EN.
- Defined:
  - In RUN, each store pushes dataadr into a TRACE_DEPTH ring.
  - When the ring is full, a push overwrites the oldest entry and sets sticky overflow bit 31 of the 0xC read.
  - Read 0xC pops the oldest entry: {ovf, 31'(addr[30:0])}.
  - Pop when empty returns 0x0000_0000 with no pointer change.
  - Push and pop in the same cycle: the pop returns the oldest entry before the push; occupancy stays the same.
- Undefined: no ring storage. 0xC reads return 0.

Test Plan:
- Reset held low 2 cycles, released mid-cycle -> state=00, done=0, pass=0, rd 0x4 and 0x8 return 0.
- Store dataadr=32 writedata=15 at cycle 5 -> next cycle done=1, pass=1, state=01; later stores leave store_cnt unchanged.
- Store dataadr=16 writedata=15, then dataadr=32 writedata=15 -> state=10 (FAIL) and stays 10, pass=0.
- Store dataadr=32 writedata=14, then no hits, TIMEOUT_CYCLES=20 -> state=11 after 20 cycles. Rd 0x4 returns 1; rd 0x8 returns 19.
- TRACE_EN, DEPTH=8: 10 stores to addresses 0,4,…,36 -> pops return 8..36 with bit31=1, then 0x0.
- Assert reset during PASS -> immediate state=00, counters=0; a subsequent store dataadr=32, writedata=15 re-enters PASS.
